decode_branch_ctrl: RTL
=======================

Name: decode_branch_ctrl

Overview:
- Consumer end of the instruction fetch interface: takes the fetch buffer word, decodes it, and drives the fetch stage's control inputs (en1, en2, branchFlag, branchAddr).
- Resolves unconditional branches in decode and squashes wrong-path fetch entries by expected-PC tracking.
- Inserts load-use stall bubbles.
- Registers decoded fields for the execute stage.

Parameters:
- REDIRECT_CYCLES, 2, number of cycles branchFlag is held high per taken branch (1..15)
- MAX_SQUASH, 8, maximum consecutive squashed entries in SQUASH state before error resync
- PC_W, 24, PC / branch address width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- bufferIn  in  56  fetch buffer word; [55:24] instruction, [23:0] PC of that instruction
- exStall  in  1  execute-stage stall request; freezes this block
- en1  out  1  fetch PC enable
- en2  out  1  fetch buffer enable
- branchFlag  out  1  redirect request to fetch
- branchAddr  out  24  redirect target
- decValid  out  1  decoded outputs hold a real instruction
- decOpcode  out  4  instr[31:28]
- decRd  out  4  instr[27:24]
- decRs1  out  4  instr[23:20]
- decRs2  out  4  instr[19:16]
- decImm  out  24  sign-extended instr[15:0]
- decPc  out  24  PC of decoded instruction
- squashErr  out  1  sticky: squash limit exceeded

Behaviour:
- Reset (rst=0, asynchronous):
  - en1=en2=1; branchFlag=0; branchAddr=0; all dec* outputs=0; squashErr=0.
  - expectedPc=0, state RUN, counters cleared.
  - Applies immediately, including mid-redirect.
- Encoding:
  - opcode 4'b1000 = LOAD.
  - opcode 4'b1101 = B (unconditional), target = pc + signext(imm16), modulo 2^24.
  - Instruction word 32'h0 = bubble; never accepted and never advances expectedPc.
- Acceptance: an entry is acceptable iff its pc == expectedPc and the instruction word is nonzero.
  - Accepted entry appears on dec* with decValid=1 one cycle later (latency 1).
  - expectedPc <= pc+4, wrapping modulo 2^24.
  - A non-accepted entry gives decValid=0 next cycle.
- en1=en2 = !(exStall | loadUseHazard); combinational.
- exStall=1 has top priority:
  - All registers, state and counters hold; dec* hold their values.
- State RUN:
  - Accepted B: branchFlag<=1, branchAddr<=target, expectedPc<=target, redirect counter<=REDIRECT_CYCLES, state<=REDIRECT.
  - The branch itself is presented on dec* with decValid=1.
  - Mismatched entry in RUN: squashed; state<=SQUASH.
- State REDIRECT:
  - branchFlag held at 1; nothing accepted; every entry squashed.
  - Counter decrements each unstalled cycle.
  - On the cycle the counter reaches 0: branchFlag<=0, state<=SQUASH.
- State SQUASH:
  - Mismatched entries squashed; squash counter increments.
  - First matching entry is accepted; state<=RUN; counter cleared.
  - When the counter reaches MAX_SQUASH: squashErr<=1 (sticky until reset), the current entry is accepted unconditionally, expectedPc<=pc+4, state<=RUN.
- Load-use hazard (RUN only):
  - Condition: decValid=1, decOpcode=LOAD, decRd!=0, and the acceptable incoming non-B instruction has rs1 or rs2 == decRd.
  - Response: en1=en2=0 that cycle; decValid<=0 (bubble); expectedPc unchanged.
  - Next cycle the held entry is accepted normally.
  - B never triggers the hazard.
- Other states: the hazard check is disabled in REDIRECT and SQUASH.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined: adds outputs statTaken[15:0] and statSquash[15:0].
  - Both are saturating counters, reset to 0.
  - statTaken increments per accepted B.
  - statSquash increments per squashed non-bubble entry.
  - Both hold while exStall=1.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, fetch entries pc 0,4,8 (instr 32'h4C40004A, 32'h80440000, 32'h4C40004A) -> decPc 0,4,8 each one cycle later; decValid=1; en1=en2=1; branchFlag=0.
- B 32'hD003FFF4 at pc 12 -> branchFlag=1 for exactly 2 cycles with branchAddr=0; entries pc 16,20 squashed (decValid=0); next pc 0 entry accepted, decPc=0.
- LOAD 32'h81400000 (rd=1) at pc 0, then 32'h4C140000 (rs1=1) at pc 4 -> en1=en2=0 for one cycle with decValid=0; the following cycle decPc=4, decValid=1.
- After B to 24'h40, feed only pc 24'h100, 24'h104, ... -> after 8 squashes squashErr=1, the ninth entry is accepted, decPc=that pc; squashErr stays 1.
- rst driven low during REDIRECT -> branchFlag=0 and all outputs at reset values before the next clock edge.
- exStall=1 for 3 cycles during REDIRECT -> branchFlag high for 5 cycles total; en1=en2=0 while stalled; dec* unchanged.

Source files
------------

// File: rtl/decode_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : decode_branch_ctrl
// Purpose  : Decode stage that reads the fetch buffer word. It resolves
//            unconditional branches, squashes wrong-path entries by tracking
//            the expected PC, inserts load-use bubbles, and registers the
//            decoded fields for execute.
// Options  : BRANCH_STATS_EN adds the statTaken and statSquash counters.
// Revision : 1.0 - initial release
// ============================================================================
module decode_branch_ctrl #(
  parameter int REDIRECT_CYCLES = 2,
  parameter int MAX_SQUASH      = 8,
  parameter int PC_W            = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [32+PC_W-1:0]   bufferIn,
  input  logic                 exStall,
  output logic                 en1,
  output logic                 en2,
  output logic                 branchFlag,
  output logic [PC_W-1:0]      branchAddr,
  output logic                 decValid,
  output logic [3:0]           decOpcode,
  output logic [3:0]           decRd,
  output logic [3:0]           decRs1,
  output logic [3:0]           decRs2,
  output logic [PC_W-1:0]      decImm,
  output logic [PC_W-1:0]      decPc,
`ifdef BRANCH_STATS_EN
  output logic [15:0]          statTaken,
  output logic [15:0]          statSquash,
`endif
  output logic                 squashErr
);

  localparam logic [3:0] OP_LOAD = 4'b1000;
  localparam logic [3:0] OP_B    = 4'b1101;
  localparam int         SQ_W    = $clog2(MAX_SQUASH + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_SQUASH   = 2'd2
  } state_t;

  state_t            state;
  logic [PC_W-1:0]   expected_pc;
  logic [3:0]        redir_cnt;
  logic [SQ_W-1:0]   squash_cnt;

  // Fields of the incoming fetch entry
  logic [31:0]       instr;
  logic [PC_W-1:0]   pc;
  logic [3:0]        in_op;
  logic [3:0]        in_rd;
  logic [3:0]        in_rs1;
  logic [3:0]        in_rs2;
  logic [PC_W-1:0]   in_imm;
  logic [PC_W-1:0]   pc_next;
  logic [PC_W-1:0]   br_target;
  logic              instr_nz;
  logic              pc_match;
  logic              is_b;
  logic              hazard;
  logic              take;
  logic              forced;
  logic              squash;
  logic              branch_take;

  assign instr     = bufferIn[32+PC_W-1:PC_W];
  assign pc        = bufferIn[PC_W-1:0];
  assign in_op     = instr[31:28];
  assign in_rd     = instr[27:24];
  assign in_rs1    = instr[23:20];
  assign in_rs2    = instr[19:16];
  assign in_imm    = {{(PC_W-16){instr[15]}}, instr[15:0]};
  assign pc_next   = pc + PC_W'(4);
  assign br_target = pc + in_imm;
  assign instr_nz  = (instr != 32'h0);
  assign pc_match  = instr_nz && (pc == expected_pc);
  assign is_b      = (in_op == OP_B);

  // Load-use hazard: the instruction just decoded is a LOAD whose result the
  // acceptable incoming instruction reads; only checked while running.
  assign hazard = (state == ST_RUN) && decValid && (decOpcode == OP_LOAD) &&
                  (decRd != 4'd0) && pc_match && !is_b &&
                  ((in_rs1 == decRd) || (in_rs2 == decRd));

  assign en1 = !(exStall || hazard);
  assign en2 = !(exStall || hazard);

  // Classify the current entry: accepted, force-accepted after too many
  // squashes, or squashed. Bubbles are neither accepted nor squashed.
  always_comb begin
    take   = 1'b0;
    forced = 1'b0;
    squash = 1'b0;
    case (state)
      ST_RUN: begin
        take   = pc_match && !hazard;
        squash = instr_nz && !pc_match;
      end
      ST_REDIRECT: begin
        squash = instr_nz;
      end
      ST_SQUASH: begin
        forced = instr_nz && !pc_match && (squash_cnt == SQ_W'(MAX_SQUASH));
        take   = pc_match || forced;
        squash = instr_nz && !pc_match && !forced;
      end
      default: begin
        take = 1'b0;
      end
    endcase
  end

  // A forced resync never follows the branch; it only restarts at pc+4.
  assign branch_take = take && is_b && !forced;

  // Main control state, PC tracking and decoded-field registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_RUN;
      expected_pc <= '0;
      redir_cnt   <= 4'd0;
      squash_cnt  <= '0;
      branchFlag  <= 1'b0;
      branchAddr  <= '0;
      decValid    <= 1'b0;
      decOpcode   <= 4'd0;
      decRd       <= 4'd0;
      decRs1      <= 4'd0;
      decRs2      <= 4'd0;
      decImm      <= '0;
      decPc       <= '0;
      squashErr   <= 1'b0;
    end else if (!exStall) begin
      decValid <= take;
      if (take) begin
        decOpcode <= in_op;
        decRd     <= in_rd;
        decRs1    <= in_rs1;
        decRs2    <= in_rs2;
        decImm    <= in_imm;
        decPc     <= pc;
      end

      if (branch_take) begin
        expected_pc <= br_target;
        branchFlag  <= 1'b1;
        branchAddr  <= br_target;
        redir_cnt   <= 4'(REDIRECT_CYCLES);
      end else if (take) begin
        expected_pc <= pc_next;
      end

      if (forced) begin
        squashErr <= 1'b1;
      end

      case (state)
        ST_RUN: begin
          if (branch_take) begin
            state <= ST_REDIRECT;
          end else if (squash) begin
            state      <= ST_SQUASH;
            squash_cnt <= '0;
          end
        end
        ST_REDIRECT: begin
          redir_cnt <= redir_cnt - 4'd1;
          if (redir_cnt == 4'd1) begin
            branchFlag <= 1'b0;
            state      <= ST_SQUASH;
            squash_cnt <= '0;
          end
        end
        ST_SQUASH: begin
          if (take) begin
            squash_cnt <= '0;
            state      <= branch_take ? ST_REDIRECT : ST_RUN;
          end else if (squash) begin
            squash_cnt <= squash_cnt + SQ_W'(1);
          end
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  // Saturating counters of taken branches and squashed real entries
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      statTaken  <= 16'd0;
      statSquash <= 16'd0;
    end else if (!exStall) begin
      if (branch_take && (statTaken != 16'hFFFF)) begin
        statTaken <= statTaken + 16'd1;
      end
      if (squash && (statSquash != 16'hFFFF)) begin
        statSquash <= statSquash + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
